// File: rtl/multi_buffer_ram_pkg.sv
// Shared helpers for the multi-buffer RAM: bit-width derivation for indices.
package multi_buffer_ram_pkg;

    // Index width for n entries, never narrower than one bit.
    function automatic int unsigned bw(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_buffer_ram_ctrl.sv
// Buffer ownership control: producer/consumer pointers, committed count, status.
// MBUF_LEN_TRACK_EN adds a per-buffer length table and the rd_len output.
module multi_buffer_ram_ctrl
    import multi_buffer_ram_pkg::*;
#(
    parameter int unsigned NUM_BUF = 2,
    parameter int unsigned BUF_W   = bw(NUM_BUF)
`ifdef MBUF_LEN_TRACK_EN
    ,
    parameter int unsigned ADDR_W  = 8
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_en,
    input  logic              wr_done,
    input  logic              rd_done,
`ifdef MBUF_LEN_TRACK_EN
    input  logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W:0]   rd_len,
`endif
    output logic              wr_accept,
    output logic [BUF_W-1:0]  wr_ptr,
    output logic [BUF_W-1:0]  rd_ptr,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [BUF_W:0]    buf_cnt
);

    localparam logic [BUF_W:0]   FullCnt = (BUF_W + 1)'(NUM_BUF);
    localparam logic [BUF_W:0]   CntOne  = (BUF_W + 1)'(1);
    localparam logic [BUF_W-1:0] LastPtr = BUF_W'(NUM_BUF - 1);
    localparam logic [BUF_W-1:0] PtrOne  = BUF_W'(1);

    logic [BUF_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [BUF_W:0]   cnt_q, cnt_d;
    logic             wr_commit, rd_release;

    assign wr_ready  = (cnt_q != FullCnt);
    assign rd_valid  = (cnt_q != '0);
    assign buf_cnt   = cnt_q;
    assign wr_ptr    = wr_ptr_q;
    assign rd_ptr    = rd_ptr_q;
    assign wr_accept = wr_en & wr_ready;

    always_comb begin
        wr_commit  = wr_done & wr_ready;
        rd_release = rd_done & rd_valid;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (wr_commit) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrOne;
            if (rd_release) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrOne;
            if (wr_commit && !rd_release)      cnt_d = cnt_q + CntOne;
            else if (!wr_commit && rd_release) cnt_d = cnt_q - CntOne;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef MBUF_LEN_TRACK_EN
    localparam logic [ADDR_W:0] LenOne = (ADDR_W + 1)'(1);

    logic [ADDR_W:0] max_q, max_d, wr_len, commit_len;
    logic [ADDR_W:0] len_q [NUM_BUF];
    logic [ADDR_W:0] len_d [NUM_BUF];

    // Running max(addr)+1 of the producer buffer, including a write in the commit cycle.
    always_comb begin
        wr_len     = {1'b0, wr_addr} + LenOne;
        commit_len = (wr_accept && (wr_len > max_q)) ? wr_len : max_q;
        max_d      = (clear || wr_commit) ? '0 : commit_len;
        len_d      = len_q;
        if (!clear && wr_commit) len_d[wr_ptr_q] = commit_len;
        rd_len     = rd_valid ? len_q[rd_ptr_q] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q <= '0;
            for (int i = 0; i < NUM_BUF; i++) len_q[i] <= '0;
        end else begin
            max_q <= max_d;
            len_q <= len_d;
        end
    end
`endif

endmodule

// File: rtl/sdp_sync_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with a registered output.
module sdp_sync_ram #(
    parameter int unsigned DEPTH    = 512,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDR_W   = 9,
    parameter string       RAM_TYPE = "block"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] rdata_q, rdata_d;

    if (RAM_TYPE == "distributed") begin : g_lutram
        (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (we) mem[waddr] <= wdata;
        end
        assign rdata_d = mem[raddr];
    end else begin : g_bram
        (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (we) mem[waddr] <= wdata;
        end
        assign rdata_d = mem[raddr];
    end

    // Output register; a same-address write on this edge is not visible (read-first).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/multi_buffer_ram.sv
// N-deep multi-buffer RAM between one producer and one consumer with FIFO buffer handoff.
// Defining MBUF_LEN_TRACK_EN adds the rd_len output (per-buffer written length).
module multi_buffer_ram
    import multi_buffer_ram_pkg::*;
#(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned WIDTH    = 512,
    parameter int unsigned NUM_BUF  = 2,
    parameter string       RAM_TYPE = "block",
    parameter int unsigned ADDR_W   = bw(DEPTH),
    parameter int unsigned BUF_W    = bw(NUM_BUF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              wr_done,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    input  logic              rd_done,
    output logic              rd_valid,
`ifdef MBUF_LEN_TRACK_EN
    output logic [ADDR_W:0]   rd_len,
`endif
    output logic [BUF_W:0]    buf_cnt
);

    localparam int unsigned PhysW    = BUF_W + ADDR_W;
    localparam int unsigned RamDepth = NUM_BUF * DEPTH;

    logic             wr_accept;
    logic [BUF_W-1:0] wr_ptr, rd_ptr;
    logic             we_q, we_d;
    logic [PhysW-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;

    multi_buffer_ram_ctrl #(
        .NUM_BUF (NUM_BUF),
        .BUF_W   (BUF_W)
`ifdef MBUF_LEN_TRACK_EN
        ,
        .ADDR_W  (ADDR_W)
`endif
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .wr_en     (wr_en),
        .wr_done   (wr_done),
        .rd_done   (rd_done),
`ifdef MBUF_LEN_TRACK_EN
        .wr_addr   (wr_addr),
        .rd_len    (rd_len),
`endif
        .wr_accept (wr_accept),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .wr_ready  (wr_ready),
        .rd_valid  (rd_valid),
        .buf_cnt   (buf_cnt)
    );

    // Pointers are sampled before this cycle's commit/release, so same-cycle
    // accesses hit the old buffers.
    always_comb begin
        we_d    = wr_accept;
        waddr_d = {wr_ptr, wr_addr};
        wdata_d = wr_data;
        raddr_d = {rd_ptr, rd_addr};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            raddr_q <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            raddr_q <= raddr_d;
        end
    end

    sdp_sync_ram #(
        .DEPTH    (RamDepth),
        .WIDTH    (WIDTH),
        .ADDR_W   (PhysW),
        .RAM_TYPE (RAM_TYPE)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we_q),
        .waddr (waddr_q),
        .wdata (wdata_q),
        .raddr (raddr_q),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_multi_buffer_ram.sv
// Self-checking bench for multi_buffer_ram (NUM_BUF=3); MBUF_LEN_TRACK_EN enables rd_len checks.
module tb_multi_buffer_ram;

    localparam int unsigned DEPTH   = 256;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned NUM_BUF = 3;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned BUF_W   = 2;

    logic              clk = 1'b0;
    logic              rst, clear, wr_en, wr_done, rd_done;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [WIDTH-1:0]  wr_data, rd_data;
    logic              wr_ready, rd_valid;
    logic [BUF_W:0]    buf_cnt;
`ifdef MBUF_LEN_TRACK_EN
    logic [ADDR_W:0]   rd_len;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multi_buffer_ram #(
        .DEPTH   (DEPTH),
        .WIDTH   (WIDTH),
        .NUM_BUF (NUM_BUF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_done  (wr_done),
        .wr_ready (wr_ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_done  (rd_done),
        .rd_valid (rd_valid),
`ifdef MBUF_LEN_TRACK_EN
        .rd_len   (rd_len),
`endif
        .buf_cnt  (buf_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic commit();
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
    endtask

    task automatic release_buf();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
    endtask

    task automatic write_buf(input int n, input logic [WIDTH-1:0] base);
        for (int a = 0; a < n; a++) begin
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(a);
            wr_data = base + WIDTH'(a);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if (rd_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_rd_data_held: got %h want 0", rd_data);
        end
        rst = 1'b0;
        #2;
        n_tests++;
        if (wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready);
        end
        n_tests++;
        if (rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid);
        end
        n_tests++;
        if (buf_cnt !== 3'd0) begin
            n_fail++; $display("FAIL reset_buf_cnt: got %0d want 0", buf_cnt);
        end
        n_tests++;
        if (rd_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data);
        end
`ifdef MBUF_LEN_TRACK_EN
        n_tests++;
        if (rd_len !== 9'd0) begin
            n_fail++; $display("FAIL reset_rd_len: got %0d want 0", rd_len);
        end
`endif
        tick();
    endtask

    task automatic test_fill_read();
        write_buf(256, 32'h100);
        n_tests++;
        if (rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL fill_valid_before_commit: got %b want 0", rd_valid);
        end
        commit();
        n_tests++;
        if (rd_valid !== 1'b1) begin
            n_fail++; $display("FAIL fill_rd_valid: got %b want 1", rd_valid);
        end
        n_tests++;
        if (buf_cnt !== 3'd1) begin
            n_fail++; $display("FAIL fill_buf_cnt: got %0d want 1", buf_cnt);
        end
        rd_addr = 8'd0;
        repeat (3) tick();
        n_tests++;
        if (rd_data !== 32'h100) begin
            n_fail++; $display("FAIL fill_read_addr0: got %h want 100", rd_data);
        end
        rd_addr = 8'd5;
        tick();
        n_tests++;
        if (rd_data !== 32'h100) begin
            n_fail++; $display("FAIL fill_latency_early: got %h want 100", rd_data);
        end
        tick();
        n_tests++;
        if (rd_data !== 32'h105) begin
            n_fail++; $display("FAIL fill_read_addr5: got %h want 105", rd_data);
        end
        release_buf();
        n_tests++;
        if (buf_cnt !== 3'd0) begin
            n_fail++; $display("FAIL fill_release_cnt: got %0d want 0", buf_cnt);
        end
    endtask

    task automatic test_full();
        do_clear();
        write_buf(4, 32'hA000); commit();
        write_buf(4, 32'hB000); commit();
        write_buf(4, 32'hC000); commit();
        n_tests++;
        if (wr_ready !== 1'b0 || buf_cnt !== 3'd3) begin
            n_fail++; $display("FAIL full_status: got ready=%b cnt=%0d want ready=0 cnt=3",
                               wr_ready, buf_cnt);
        end
        wr_en = 1'b1; wr_addr = 8'd0; wr_data = 32'hDEAD; wr_done = 1'b1;
        tick();
        wr_en = 1'b0; wr_done = 1'b0;
        n_tests++;
        if (wr_ready !== 1'b0 || buf_cnt !== 3'd3) begin
            n_fail++; $display("FAIL full_ignored_commit: got ready=%b cnt=%0d want 0/3",
                               wr_ready, buf_cnt);
        end
        rd_addr = 8'd0;
        tick(); tick();
        n_tests++;
        if (rd_data !== 32'hA000) begin
            n_fail++; $display("FAIL full_buf0_intact: got %h want a000", rd_data);
        end
        release_buf();
        n_tests++;
        if (wr_ready !== 1'b1 || buf_cnt !== 3'd2) begin
            n_fail++; $display("FAIL full_after_release: got ready=%b cnt=%0d want 1/2",
                               wr_ready, buf_cnt);
        end
        tick(); tick();
        n_tests++;
        if (rd_data !== 32'hB000) begin
            n_fail++; $display("FAIL full_buf1_read: got %h want b000", rd_data);
        end
        // Recommit buffer 0 untouched and rotate the consumer back onto it.
        commit();
        release_buf();
        release_buf();
        n_tests++;
        if (buf_cnt !== 3'd1) begin
            n_fail++; $display("FAIL full_rotate_cnt: got %0d want 1", buf_cnt);
        end
        rd_addr = 8'd0;
        tick(); tick();
        n_tests++;
        if (rd_data !== 32'hA000) begin
            n_fail++; $display("FAIL full_dropped_write: got %h want a000", rd_data);
        end
        rd_addr = 8'd1;
        tick(); tick();
        n_tests++;
        if (rd_data !== 32'hA001) begin
            n_fail++; $display("FAIL full_buf0_addr1: got %h want a001", rd_data);
        end
    endtask

    task automatic test_simul();
        do_clear();
        write_buf(4, 32'h5000); commit();
        write_buf(4, 32'h6000);
        rd_addr = 8'd2; wr_done = 1'b1; rd_done = 1'b1;
        tick();
        wr_done = 1'b0; rd_done = 1'b0;
        n_tests++;
        if (buf_cnt !== 3'd1) begin
            n_fail++; $display("FAIL simul_cnt: got %0d want 1", buf_cnt);
        end
        rd_addr = 8'd3;
        tick();
        n_tests++;
        if (rd_data !== 32'h5002) begin
            n_fail++; $display("FAIL simul_old_buf_read: got %h want 5002", rd_data);
        end
        tick();
        n_tests++;
        if (rd_data !== 32'h6003) begin
            n_fail++; $display("FAIL simul_rd_ptr1: got %h want 6003", rd_data);
        end
        write_buf(1, 32'h7000); commit();
        release_buf();
        rd_addr = 8'd0;
        tick(); tick();
        n_tests++;
        if (rd_data !== 32'h7000) begin
            n_fail++; $display("FAIL simul_wr_ptr2: got %h want 7000", rd_data);
        end
    endtask

    task automatic test_clear();
        do_clear();
        write_buf(4, 32'h8000); commit();
        write_buf(4, 32'h9000); commit();
        n_tests++;
        if (buf_cnt !== 3'd2) begin
            n_fail++; $display("FAIL clear_setup_cnt: got %0d want 2", buf_cnt);
        end
        clear = 1'b1; wr_done = 1'b1; rd_addr = 8'd1;
        tick();
        clear = 1'b0; wr_done = 1'b0;
        n_tests++;
        if (buf_cnt !== 3'd0 || wr_ready !== 1'b1 || rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL clear_status: got cnt=%0d ready=%b valid=%b want 0/1/0",
                               buf_cnt, wr_ready, rd_valid);
        end
        tick();
        n_tests++;
        if (rd_data !== 32'h8001) begin
            n_fail++; $display("FAIL clear_inflight_read: got %h want 8001", rd_data);
        end
        wr_en = 1'b1; wr_addr = 8'd2; wr_data = 32'hBEEF; rd_addr = 8'd2;
        tick();
        wr_en = 1'b0;
        tick();
        n_tests++;
        if (rd_data !== 32'h8002) begin
            n_fail++; $display("FAIL clear_collision_old: got %h want 8002", rd_data);
        end
        commit();
        n_tests++;
        if (buf_cnt !== 3'd1) begin
            n_fail++; $display("FAIL clear_recommit_cnt: got %0d want 1", buf_cnt);
        end
        tick(); tick();
        n_tests++;
        if (rd_data !== 32'hBEEF) begin
            n_fail++; $display("FAIL clear_write_landed: got %h want beef", rd_data);
        end
    endtask

`ifdef MBUF_LEN_TRACK_EN
    task automatic test_len();
        do_clear();
        for (int a = 9; a >= 0; a--) begin
            wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = WIDTH'(a);
            tick();
        end
        wr_en = 1'b0;
        commit();
        commit();
        n_tests++;
        if (rd_len !== 9'd10) begin
            n_fail++; $display("FAIL len_ten: got %0d want 10", rd_len);
        end
        release_buf();
        n_tests++;
        if (rd_len !== 9'd0 || rd_valid !== 1'b1) begin
            n_fail++; $display("FAIL len_empty_buf: got len=%0d valid=%b want 0/1",
                               rd_len, rd_valid);
        end
        release_buf();
        n_tests++;
        if (rd_len !== 9'd0 || rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL len_none: got len=%0d valid=%b want 0/0", rd_len, rd_valid);
        end
    endtask
`endif

    // Reference: FIFO of committed buffer ids plus a flat word array per buffer.
    task automatic test_random();
        logic [WIDTH-1:0] m_mem [NUM_BUF*DEPTH];
        bit               m_wr [NUM_BUF*DEPTH];
        int               m_q[$];
        int               m_len [NUM_BUF];
        int               m_prod, m_max, idx, pd, pr;
        bit               p1_v, p2_v, iss_v, rdy, val;
        logic [WIDTH-1:0] p1_d, p2_d, iss_d;
        foreach (m_wr[i]) m_wr[i] = 1'b0;
        foreach (m_len[i]) m_len[i] = 0;
        do_clear();
        m_prod = 0; m_max = 0;
        p1_v = 1'b0; p2_v = 1'b0; p1_d = '0; p2_d = '0;
        for (int c = 0; c < 600; c++) begin
            n_tests++;
            if (int'(buf_cnt) != m_q.size()) begin
                n_fail++; $display("FAIL rand_buf_cnt c=%0d: got %0d want %0d", c, buf_cnt,
                                   m_q.size());
            end
            n_tests++;
            if (wr_ready !== (m_q.size() != NUM_BUF) || rd_valid !== (m_q.size() != 0)) begin
                n_fail++; $display("FAIL rand_status c=%0d: got ready=%b valid=%b size=%0d",
                                   c, wr_ready, rd_valid, m_q.size());
            end
            if (p2_v) begin
                n_tests++;
                if (rd_data !== p2_d) begin
                    n_fail++; $display("FAIL rand_rd_data c=%0d: got %h want %h", c, rd_data,
                                       p2_d);
                end
            end
`ifdef MBUF_LEN_TRACK_EN
            n_tests++;
            if (int'(rd_len) != ((m_q.size() != 0) ? m_len[m_q[0]] : 0)) begin
                n_fail++; $display("FAIL rand_rd_len c=%0d: got %0d", c, rd_len);
            end
`endif
            pd = (c < 300) ? 5 : 20;
            pr = (c < 300) ? 20 : 5;
            wr_en   = ($urandom_range(0, 9) < 7);
            wr_addr = ADDR_W'($urandom_range(0, 15));
            wr_data = $urandom;
            wr_done = ($urandom_range(0, pd - 1) == 0);
            rd_done = ($urandom_range(0, pr - 1) == 0);
            rd_addr = ADDR_W'($urandom_range(0, 15));
            rdy = (m_q.size() != NUM_BUF);
            val = (m_q.size() != 0);
            iss_v = 1'b0; iss_d = '0;
            if (val) begin
                idx   = m_q[0] * DEPTH + int'(rd_addr);
                iss_v = m_wr[idx];
                iss_d = m_mem[idx];
            end
            tick();
            if (wr_en && rdy) begin
                idx = m_prod * DEPTH + int'(wr_addr);
                m_mem[idx] = wr_data;
                m_wr[idx]  = 1'b1;
                if (int'(wr_addr) + 1 > m_max) m_max = int'(wr_addr) + 1;
            end
            if (wr_done && rdy) begin
                m_len[m_prod] = m_max;
                m_max = 0;
                m_q.push_back(m_prod);
                m_prod = (m_prod + 1) % NUM_BUF;
            end
            if (rd_done && val) void'(m_q.pop_front());
            p2_v = p1_v; p2_d = p1_d;
            p1_v = iss_v; p1_d = iss_d;
        end
        wr_en = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        test_reset();
        test_fill_read();
        test_full();
        test_simul();
        test_clear();
`ifdef MBUF_LEN_TRACK_EN
        test_len();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_buffer_ram.md
Name: multi_buffer_ram

Overview:
- Parametrised N-deep multi-buffer (generalised ping-pong) RAM between one producer and one consumer.
  - The producer fills a whole buffer, then commits it with wr_done.
  - The consumer reads committed buffers in FIFO order and releases each with rd_done.
- Replaces manual switch-driven ping-pong buffers with credit-style ready/valid buffer ownership.
- Sits between DDR loaders and PE-array feeders in the training datapath.

Parameters:
- DEPTH, 256: words per buffer; must be a power of two.
- WIDTH, 512: data word width in bits.
- NUM_BUF, 2: number of buffers; any value ≥2.
- RAM_TYPE, "block": passed to sdp_sync_ram.
- ADDR_W, bw(DEPTH): derived; do not override.
- BUF_W, bw(NUM_BUF): derived buffer index width; do not override.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush; drops all buffer ownership.
- wr_en  in  1  write strobe into the current producer buffer.
- wr_addr  in  ADDR_W  word address within the buffer.
- wr_data  in  WIDTH  write data.
- wr_done  in  1  commit the current producer buffer.
- wr_ready  out  1  a free buffer is owned by the producer.
- rd_addr  in  ADDR_W  word address within the consumer buffer.
- rd_data  out  WIDTH  read data; 2-cycle latency.
- rd_done  in  1  release the current consumer buffer.
- rd_valid  out  1  a committed buffer is available to the consumer.
- buf_cnt  out  BUF_W+1  number of committed, unreleased buffers.

Behaviour:
- State: wr_ptr and rd_ptr (0..NUM_BUF-1, wrap from NUM_BUF-1 to 0) and cnt (0..NUM_BUF).
- Reset (rst high, async): wr_ptr=0, rd_ptr=0, cnt=0, rd_data=0; therefore wr_ready=1, rd_valid=0, buf_cnt=0.
- Status outputs: wr_ready = (cnt != NUM_BUF); rd_valid = (cnt != 0); buf_cnt = cnt. All three are combinational from registers.
- Writes:
  - wr_en is honoured only when wr_ready=1; otherwise the write is dropped.
  - The physical write address is {wr_ptr, wr_addr} and is registered one cycle before the RAM, so the write lands at t+1.
  - A write in the same cycle as wr_done targets the old wr_ptr.
- Commit: wr_done with wr_ready=1 advances wr_ptr and increments cnt. wr_done with wr_ready=0 is ignored.
- Reads:
  - rd_addr is always sampled at t; the physical address is {rd_ptr, rd_addr}.
  - Stage 1 registers the address; stage 2 is the RAM output register (HIGH_PERFORMANCE mode).
  - rd_data is valid at t+2.
  - A read issued in the same cycle as rd_done uses the old rd_ptr.
  - When rd_valid=0, rd_data is don't-care.
- Release: rd_done with rd_valid=1 advances rd_ptr and decrements cnt. rd_done with rd_valid=0 is ignored.
- Simultaneous accepted wr_done and rd_done: both pointers advance and cnt is unchanged. This holds at cnt=NUM_BUF only if wr_done is ignored there; evaluate wr_ready/rd_valid before the update.
- clear:
  - Sets pointers and cnt to 0 next cycle and overrides wr_done/rd_done in the same cycle.
  - RAM contents are untouched.
  - Reads in flight still complete.
- Read/write collision on the same physical address in the same cycle is impossible by ownership (the producer and consumer buffers differ) except after clear. After clear the read returns old data.
- Memory: one sdp_sync_ram of depth NUM_BUF*DEPTH, indexed {buf_idx, addr}. With non-power-of-two NUM_BUF the unused tail is never addressed.

Optional Feature:
- Macro: MBUF_LEN_TRACK_EN.
- With the macro defined:
  - Each buffer stores a length register, max(accepted wr_addr)+1, captured when the buffer is committed.
  - Extra output rd_len (ADDR_W+1 bits) gives the length of the rd_ptr buffer; it is 0 when rd_valid=0 and 0 after reset or clear.
  - A committed buffer with no writes has length 0.
- Without the macro: no rd_len port and no length registers.

Decomposition:
- GLOBAL_PARAM supplies bw(); nothing else is needed in a package. Optionally add MBUF_RD_LAT=2 as a shared constant for consumers' pipeline alignment.
- Natural sub-module: mbuf_ctrl, holding the pointers, cnt, ready/valid and the optional length table. The datapath instantiates sdp_sync_ram directly.

Test Plan:
1. Reset then idle, NUM_BUF=2.
   - Stimulus: hold reset, release, leave all inputs idle.
   - Required: wr_ready=1, rd_valid=0, buf_cnt=0, rd_data=0.
2. Basic fill and read back.
   - Stimulus: write addr 0..255 with data=addr+0x100, pulse wr_done, then read addr 5.
   - Required: rd_valid=1 the next cycle, buf_cnt=1; reading addr 5 returns 0x105 exactly 2 cycles later.
3. Full condition.
   - Stimulus: NUM_BUF=3; commit 3 buffers; attempt a 4th write of 0xDEAD to addr 0 and a wr_done.
   - Required: wr_ready=0, buf_cnt=3; after one rd_done, buffer 0 still reads its original data and the dropped write never appears.
4. Simultaneous commit and release.
   - Stimulus: at buf_cnt=1, assert wr_done and rd_done in the same cycle.
   - Required: buf_cnt stays 1, rd_ptr=1, wr_ptr=2 mod NUM_BUF; the read issued that cycle returns old-buffer data.
5. Flush.
   - Stimulus: at buf_cnt=2, assert clear together with wr_done.
   - Required: buf_cnt=0, wr_ready=1, rd_valid=0 the next cycle; wr_done is ignored.
6. Length tracking (MBUF_LEN_TRACK_EN defined).
   - Stimulus: commit a buffer with writes to addr 0..9, then commit a buffer with no writes.
   - Required: rd_len=10, then 0 after rd_done.
